// File: rtl/ps2_rx_ctrl_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PARITY  = 2'd1;
  localparam logic [1:0] ERR_STOP    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// Byte-level interface between the PS/2 receiver and its consumer (scan-code decoder).
interface ps2_rx_ctrl_if;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [1:0] err_code;
  logic       busy;

  modport master (input rx_en, output rx_data, rx_valid, rx_err, err_code, busy);
  modport slave  (output rx_en, input rx_data, rx_valid, rx_err, err_code, busy);
endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 pins, de-glitches ps2_clk and emits a one-cycle
// pulse on each filtered falling edge alongside the synchronised data bit.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_tick,
  output logic data_sync
);
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             filt_q, filt_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the filtered level restarts the run count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_s2_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                                 cnt_d  = cnt_q + CNT_W'(1);
    end
    tick_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign fall_tick = tick_q;
  assign data_sync = dat_s2_q;
endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: frames start/8 data/odd parity/stop, reports
// good bytes with rx_valid and discarded frames with rx_err + err_code.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_ctrl_if.master rx_if
);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  logic fall_tick, data_bit;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall_tick (fall_tick),
    .data_sync (data_bit)
  );

  ps2_state_t       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_err_q, rx_err_d;
  logic [1:0]       err_code_q, err_code_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = '0;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    err_code_d = err_code_q;

    if (state_q == S_IDLE) begin
      if (fall_tick && rx_if.rx_en && !data_bit) begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
    end else if (fall_tick) begin
      // A bit arriving on the expiry cycle takes precedence over the timeout.
      unique case (state_q)
        S_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = data_bit;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!(^{shift_q, parity_q})) begin
            rx_err_d   = 1'b1;
            err_code_d = ERR_PARITY;
          end else if (!data_bit) begin
            rx_err_d   = 1'b1;
            err_code_d = ERR_STOP;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
      state_d    = S_IDLE;
      rx_err_d   = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      err_code_q <= err_code_d;
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign rx_if.rx_err   = rx_err_q;
  assign rx_if.err_code = err_code_q;
  assign rx_if.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: table of whole frames plus hand-written
// sequences for timeout, glitches, rx_en gating and mid-frame reset.
module tb_ps2_rx_ctrl;
  import ps2_pkg::*;

  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 50;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  ps2_rx_ctrl_if rx_if();

  ps2_rx_ctrl #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_if    (rx_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         valid_cnt, err_cnt, overlap_cnt;
  logic       busy_seen;
  logic [7:0] last_data;
  logic [1:0] last_code;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_if.rx_valid) begin
        valid_cnt++;
        last_data = rx_if.rx_data;
        $display("[TB] t=%0t rx_valid data=0x%02h", $time, rx_if.rx_data);
      end
      if (rx_if.rx_err) begin
        err_cnt++;
        last_code = rx_if.err_code;
        $display("[TB] t=%0t rx_err code=%0d", $time, rx_if.err_code);
      end
      if (rx_if.rx_valid && rx_if.rx_err) overlap_cnt++;
      if (rx_if.busy) busy_seen = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    valid_cnt = 0;
    err_cnt   = 0;
    busy_seen = 1'b0;
  endtask

  // Drives the first nbits of a frame; rx_en drops at bit index en_drop_bit (-1 = never).
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input int en_drop_bit);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == en_drop_bit) rx_if.rx_en = 1'b0;
      ps2_data = f[i];
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [1:0] exp_code;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 2'd0, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 2'd1, 8'h1C};
    vecs[2] = '{8'hF0, 1'b1, 1'b0, 0, 1, 2'd2, 8'h1C};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1, 0, 2'd2, 8'h5A};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1, 0, 2'd2, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1, 0, 2'd2, 8'hFF};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 0, 1, 2'd1, 8'hFF};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 0, 1, 2'd1, 8'hFF};

    overlap_cnt = 0;
    valid_cnt   = 0;
    err_cnt     = 0;
    busy_seen   = 1'b0;
    last_data   = '0;
    last_code   = '0;
    reset       = 1'b1;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    rx_if.rx_en = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rx_data",  32'(rx_if.rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("reset_rx_err",   32'(rx_if.rx_err), 32'd0);
    chk("reset_err_code", 32'(rx_if.err_code), 32'd0);
    chk("reset_busy",     32'(rx_if.busy), 32'd0);

    for (int v = 0; v < 8; v++) begin
      clear_mon();
      send_frame(vecs[v].d, vecs[v].par, vecs[v].stop, PS2_FRAME_BITS, -1);
      repeat (30) @(negedge clk);
      $display("[TB] vec %0d byte=0x%02h par=%0b stop=%0b valid=%0d err=%0d code=%0d data=0x%02h",
               v, vecs[v].d, vecs[v].par, vecs[v].stop, valid_cnt, err_cnt,
               rx_if.err_code, rx_if.rx_data);
      chk($sformatf("vec%0d_valid_cnt", v), 32'(valid_cnt), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_err_cnt", v),   32'(err_cnt),   32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_err_code", v),  32'(rx_if.err_code), 32'(vecs[v].exp_code));
      chk($sformatf("vec%0d_rx_data", v),   32'(rx_if.rx_data),  32'(vecs[v].exp_data));
      chk($sformatf("vec%0d_busy", v),      32'(rx_if.busy), 32'd0);
    end

    // rx_en dropped mid-frame: the frame still completes.
    clear_mon();
    send_frame(8'h29, 1'b0, 1'b1, PS2_FRAME_BITS, 3);
    repeat (30) @(negedge clk);
    rx_if.rx_en = 1'b1;
    $display("[TB] en_drop valid=%0d data=0x%02h", valid_cnt, rx_if.rx_data);
    chk("en_drop_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("en_drop_rx_data",   32'(rx_if.rx_data), 32'h29);

    // Timeout after start + 4 data bits of 0x33.
    clear_mon();
    send_frame(8'h33, 1'b0, 1'b1, 4, -1);
    chk("tmo_busy_mid", 32'(rx_if.busy), 32'd1);
    ps2_data = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    cnt = 0;
    while (cnt < 3000) begin
      @(posedge clk);
      cnt++;
      if (cnt == HALF) ps2_clk = 1'b1;
      @(negedge clk);
      if (rx_if.rx_err) break;
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    $display("[TB] timeout err after %0d clk code=%0d", cnt, rx_if.err_code);
    chk("tmo_latency",  32'(cnt), 32'd2011);
    chk("tmo_err_code", 32'(rx_if.err_code), 32'd3);
    @(negedge clk);
    chk("tmo_busy_after", 32'(rx_if.busy), 32'd0);
    chk("tmo_err_cnt",    32'(err_cnt), 32'd1);
    chk("tmo_valid_cnt",  32'(valid_cnt), 32'd0);
    chk("tmo_rx_data",    32'(rx_if.rx_data), 32'h29);

    // Glitches, a frame with rx_en=0 and a high start bit: nothing happens.
    repeat (100) @(negedge clk);
    clear_mon();
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (40) @(negedge clk);
    end
    rx_if.rx_en = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, PS2_FRAME_BITS, -1);
    rx_if.rx_en = 1'b1;
    ps2_data = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (100) @(negedge clk);
    $display("[TB] quiet busy_seen=%0b valid=%0d err=%0d", busy_seen, valid_cnt, err_cnt);
    chk("quiet_busy_seen", 32'(busy_seen), 32'd0);
    chk("quiet_valid_cnt", 32'(valid_cnt), 32'd0);
    chk("quiet_err_cnt",   32'(err_cnt), 32'd0);

    // Reset pulse in the middle of DATA.
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b1, 4, -1);
    chk("rst_busy_before", 32'(rx_if.busy), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    $display("[TB] mid-frame reset data=0x%02h code=%0d busy=%0b",
             rx_if.rx_data, rx_if.err_code, rx_if.busy);
    chk("rst_rx_data",  32'(rx_if.rx_data), 32'h00);
    chk("rst_err_code", 32'(rx_if.err_code), 32'd0);
    chk("rst_busy",     32'(rx_if.busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("rst_rx_err",   32'(rx_if.rx_err), 32'd0);
    repeat (200) @(negedge clk);
    chk("rst_no_strobe", 32'(valid_cnt + err_cnt), 32'd0);
    clear_mon();
    send_frame(8'hE0, 1'b0, 1'b1, PS2_FRAME_BITS, -1);
    repeat (30) @(negedge clk);
    chk("post_rst_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("post_rst_rx_data",   32'(rx_if.rx_data), 32'hE0);
    chk("post_rst_err_cnt",   32'(err_cnt), 32'd0);

    chk("no_valid_err_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
